dispatch_decoder: RTL and testbench
===================================

Name: dispatch_decoder

Overview:
- Parametrised successor of the single-instruction decoder in the dispatch stage of the Tomasulo MIPS core.
- Buffers fetched instructions in a DEPTH-entry FIFO and decodes the head entry. Routes each instruction to one of four issue queues: integer, mult, ld/st or branch.
- Stalls only when the head instruction's target queue is full, and supports a flush for branch mispredicts.

Parameters:
- DEPTH, 4, instruction buffer entries; must be a power of two and at least 2.
- DATA_W, 32, width of the extended immediate output; must be at least 16.
- PTR_W, $clog2(DEPTH), derived pointer width; never overridden.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- Inst_valid  in  1  fetch presents an instruction.
- Inst  in  32  MIPS instruction word.
- Inst_ready  out  1  buffer can accept; equals (count != DEPTH).
- flush  in  1  discard all buffered and in-flight instructions.
- integer_full, mult_full, ld_st_full, branch_full  in  1 each  issue-queue backpressure.
- Dispatch_opcode  out  4  ALU op code (see Behaviour).
- Dispatch_shfamt  out  5  Inst[10:6].
- Dispatch_rs  out  5  Inst[25:21].
- Dispatch_rt  out  5  Inst[20:16].
- Dispatch_rd  out  5  destination register: Inst[15:11] for R-type, Inst[20:16] for I-type, 0 otherwise.
- Dispatch_imm  out  DATA_W  extended Inst[15:0].
- Dispatch_jmp_addr  out  26  Inst[25:0].
- Dispatch_ld_st_op  out  1  0 = LW, 1 = SW.
- Dispatch_en_integer, Dispatch_en_mult, Dispatch_en_ld_st, Dispatch_en_branch  out  1 each  single-cycle write enables.
- Dispatch_illegal  out  1  pulse; head instruction was unsupported and has been dropped.

Behaviour:
- Reset: clears FIFO pointers and count. All Dispatch_* outputs become 0, so Inst_ready = 1.
- Accept: occurs on a rising edge when Inst_valid & Inst_ready; the word is written at the write pointer. When count == DEPTH, Inst_ready = 0 and Inst is ignored.
- Decode: combinational on the FIFO head. The head target is one of INT, MULT, LDST, BR or ILLEGAL.
- R-type (op 000000), routed to INT unless noted:
  - funct 100000 ADD=0, 100001 ADDU=1, 100010 SUB=2, 100100 AND=3, 100101 OR=4, 100111 NOR=5, 101010 SLT=6, 101011 SLTU=7, 000000 SLL=8, 000010 SRL=9.
  - funct 011000 MULT routes to MULT with opcode 0.
- I-type, routed to INT:
  - 001000 ADDI uses op ADD; 001001 ADDIU uses op ADDU; 001010 SLTI uses op SLT; all three sign-extend the immediate.
  - 001100 ANDI uses op AND; 001101 ORI uses op OR; both zero-extend the immediate.
- Memory: 100011 LW routes to LDST with ld_st_op = 0; 101011 SW routes to LDST with ld_st_op = 1; both sign-extend the immediate and use opcode ADD.
- Branch/jump: 000100 BEQ uses op SUB; 000101 BNE uses op SUB with imm sign-extended; 000010 J uses op ADD. All three route to BR.
- Any other opcode or funct is ILLEGAL.
- Dispatch fires when count != 0, the target is not full and flush = 0. On the edge:
  - the head is popped;
  - the registered outputs load the decode;
  - exactly one en (or Dispatch_illegal) is 1 for the following cycle.
- ILLEGAL is popped regardless of full flags.
- The head is blocked when its target's full flag = 1: no pop, all en = 0, and the data outputs hold their last value.
- Flags for non-target queues are ignored; there is no reordering past a blocked head.
- Latency: an instruction accepted on edge E into an empty buffer with its target not full has its en high in the cycle after edge E+1. Throughput is 1 instruction per cycle.
- Simultaneous accept and pop: count is unchanged. Accept into a full buffer is impossible; a pop on the same edge does not free the slot early.
- Pointers wrap modulo DEPTH.
- flush: the next edge sets count to 0 and equalises the pointers. All en outputs and Dispatch_illegal are forced to 0. Any accept on the same edge is dropped. flush has priority over accept and dispatch.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Decomposition:
- Package dispatch_pkg holds:
  - opcode and funct localparams;
  - the ALU op encodings 0–9;
  - target enum {T_INT, T_MULT, T_LDST, T_BR, T_ILL}.
- Sub-module inst_buffer (DEPTH-deep synchronous FIFO with count, push/pop/flush) is natural. Decode logic stays in dispatch_decoder.

Test Plan:
- Reset then ADD r3,r1,r2 (0x00221820), all full = 0: en_integer pulses one cycle; opcode 0, rs 1, rt 2, rd 3; the cycle after E+1.
- ADDI r5,r0,-4 (0x2005FFFC): imm 0xFFFFFFFC, rd 5. ORI r5,r0,0xFFFC (0x3405FFFC): imm 0x0000FFFC.
- LW r4,8(r1) (0x8C240008) with ld_st_full = 1 for 3 cycles, then 0: no en while full; en_ld_st pulses once with ld_st_op 0, imm 8. A following ADD behind it is also held.
- Fill buffer with DEPTH MULTs (0x00220018) while mult_full = 1: Inst_ready drops after DEPTH accepts. Release: DEPTH consecutive en_mult pulses, and Inst_ready returns on the first pop.
- Opcode 0x3F word: Dispatch_illegal pulses, no en fires, and the next instruction dispatches the cycle after.
- Three instructions buffered, then flush asserted together with Inst_valid: count goes to 0, no en pulses, and the flushed-cycle input is not stored. Reset pulse mid-stream: all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared encodings for the dispatch stage: MIPS opcode/funct fields, ALU op codes
// and the issue-queue target of a decoded instruction.
package dispatch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU = 6'b101011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;

  typedef enum logic [2:0] {T_INT, T_MULT, T_LDST, T_BR, T_ILL} target_e;

endpackage

// File: rtl/dispatch_decoder_inst_buffer.sv
// DEPTH-entry instruction FIFO with occupancy count; flush empties it in one edge.
module inst_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W:0]   count,
  output logic             ready
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_d;
  logic             do_push, do_pop;

  // ready comes from the current count, so a same-edge pop never frees a full slot early
  assign ready   = (count != (PTR_W+1)'(DEPTH));
  assign do_push = push & ready & ~flush;
  assign do_pop  = pop & (count != '0) & ~flush;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/dispatch_decoder.sv
// Dispatch stage: buffers fetched MIPS words, decodes the head and issues it to one of
// four issue queues, stalling only on the head's own target queue.
module dispatch_decoder
  import dispatch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Inst_valid,
  input  logic [31:0]       Inst,
  output logic              Inst_ready,
  input  logic              flush,
  input  logic              integer_full,
  input  logic              mult_full,
  input  logic              ld_st_full,
  input  logic              branch_full,
  output logic [3:0]        Dispatch_opcode,
  output logic [4:0]        Dispatch_shfamt,
  output logic [4:0]        Dispatch_rs,
  output logic [4:0]        Dispatch_rt,
  output logic [4:0]        Dispatch_rd,
  output logic [DATA_W-1:0] Dispatch_imm,
  output logic [25:0]       Dispatch_jmp_addr,
  output logic              Dispatch_ld_st_op,
  output logic              Dispatch_en_integer,
  output logic              Dispatch_en_mult,
  output logic              Dispatch_en_ld_st,
  output logic              Dispatch_en_branch,
  output logic              Dispatch_illegal
);

  logic [31:0]       head;
  logic [PTR_W:0]    count;
  logic              fire;
  logic              target_full;
  target_e           tgt;
  logic [3:0]        alu_op;
  logic [4:0]        rd;
  logic              ld_st_op;
  logic              zero_ext;
  logic signed [15:0] imm_s;
  logic [DATA_W-1:0] imm_ext;

  inst_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (32),
    .PTR_W (PTR_W)
  ) u_inst_buffer (
    .clock (clock),
    .reset (reset),
    .push  (Inst_valid),
    .pop   (fire),
    .flush (flush),
    .wdata (Inst),
    .rdata (head),
    .count (count),
    .ready (Inst_ready)
  );

  always_comb begin
    tgt      = T_ILL;
    alu_op   = ALU_ADD;
    rd       = 5'd0;
    ld_st_op = 1'b0;
    zero_ext = 1'b0;
    case (head[31:26])
      OP_RTYPE: begin
        tgt = T_INT;
        rd  = head[15:11];
        case (head[5:0])
          FUNCT_ADD:  alu_op = ALU_ADD;
          FUNCT_ADDU: alu_op = ALU_ADDU;
          FUNCT_SUB:  alu_op = ALU_SUB;
          FUNCT_AND:  alu_op = ALU_AND;
          FUNCT_OR:   alu_op = ALU_OR;
          FUNCT_NOR:  alu_op = ALU_NOR;
          FUNCT_SLT:  alu_op = ALU_SLT;
          FUNCT_SLTU: alu_op = ALU_SLTU;
          FUNCT_SLL:  alu_op = ALU_SLL;
          FUNCT_SRL:  alu_op = ALU_SRL;
          FUNCT_MULT: tgt    = T_MULT;
          default: begin
            tgt = T_ILL;
            rd  = 5'd0;
          end
        endcase
      end
      OP_ADDI:  begin tgt = T_INT; alu_op = ALU_ADD;  rd = head[20:16]; end
      OP_ADDIU: begin tgt = T_INT; alu_op = ALU_ADDU; rd = head[20:16]; end
      OP_SLTI:  begin tgt = T_INT; alu_op = ALU_SLT;  rd = head[20:16]; end
      OP_ANDI:  begin tgt = T_INT; alu_op = ALU_AND;  rd = head[20:16]; zero_ext = 1'b1; end
      OP_ORI:   begin tgt = T_INT; alu_op = ALU_OR;   rd = head[20:16]; zero_ext = 1'b1; end
      OP_LW:    begin tgt = T_LDST; ld_st_op = 1'b0; end
      OP_SW:    begin tgt = T_LDST; ld_st_op = 1'b1; end
      OP_BEQ:   begin tgt = T_BR; alu_op = ALU_SUB; end
      OP_BNE:   begin tgt = T_BR; alu_op = ALU_SUB; end
      OP_J:     begin tgt = T_BR; alu_op = ALU_ADD; end
      default:  tgt = T_ILL;
    endcase
  end

  assign imm_s   = head[15:0];
  assign imm_ext = zero_ext ? DATA_W'(head[15:0]) : DATA_W'(imm_s);

  always_comb begin
    target_full = 1'b0;
    case (tgt)
      T_INT:   target_full = integer_full;
      T_MULT:  target_full = mult_full;
      T_LDST:  target_full = ld_st_full;
      T_BR:    target_full = branch_full;
      default: target_full = 1'b0;
    endcase
  end

  // Illegal heads never block: they are dropped and reported instead
  assign fire = (count != '0) & ~flush & ~target_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Dispatch_opcode     <= '0;
      Dispatch_shfamt     <= '0;
      Dispatch_rs         <= '0;
      Dispatch_rt         <= '0;
      Dispatch_rd         <= '0;
      Dispatch_imm        <= '0;
      Dispatch_jmp_addr   <= '0;
      Dispatch_ld_st_op   <= 1'b0;
      Dispatch_en_integer <= 1'b0;
      Dispatch_en_mult    <= 1'b0;
      Dispatch_en_ld_st   <= 1'b0;
      Dispatch_en_branch  <= 1'b0;
      Dispatch_illegal    <= 1'b0;
    end else begin
      Dispatch_en_integer <= fire & (tgt == T_INT);
      Dispatch_en_mult    <= fire & (tgt == T_MULT);
      Dispatch_en_ld_st   <= fire & (tgt == T_LDST);
      Dispatch_en_branch  <= fire & (tgt == T_BR);
      Dispatch_illegal    <= fire & (tgt == T_ILL);
      if (fire) begin
        Dispatch_opcode   <= alu_op;
        Dispatch_shfamt   <= head[10:6];
        Dispatch_rs       <= head[25:21];
        Dispatch_rt       <= head[20:16];
        Dispatch_rd       <= rd;
        Dispatch_imm      <= imm_ext;
        Dispatch_jmp_addr <= head[25:0];
        Dispatch_ld_st_op <= ld_st_op;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_decoder.sv
// Directed bench for dispatch_decoder with hand-computed expectations.
module tb_dispatch_decoder;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] W_ADD  = 32'h0022_1820; // add r3,r1,r2
  localparam logic [31:0] W_SUB  = 32'h0022_1822; // sub r3,r1,r2
  localparam logic [31:0] W_OR   = 32'h0022_1825;
  localparam logic [31:0] W_SRL  = 32'h0002_1902; // srl r3,r2,4
  localparam logic [31:0] W_ADDI = 32'h2005_FFFC;
  localparam logic [31:0] W_ORI  = 32'h3405_FFFC;
  localparam logic [31:0] W_LW   = 32'h8C24_0008;
  localparam logic [31:0] W_MULT = 32'h0022_0018;
  localparam logic [31:0] W_BEQ  = 32'h1022_0004;
  localparam logic [31:0] W_J    = 32'h0800_0010;
  localparam logic [31:0] W_ILL  = 32'hFC00_0000;

  logic              clock = 1'b0;
  logic              reset;
  logic              Inst_valid;
  logic [31:0]       Inst;
  logic              Inst_ready;
  logic              flush;
  logic              integer_full, mult_full, ld_st_full, branch_full;
  logic [3:0]        Dispatch_opcode;
  logic [4:0]        Dispatch_shfamt, Dispatch_rs, Dispatch_rt, Dispatch_rd;
  logic [DATA_W-1:0] Dispatch_imm;
  logic [25:0]       Dispatch_jmp_addr;
  logic              Dispatch_ld_st_op;
  logic              Dispatch_en_integer, Dispatch_en_mult, Dispatch_en_ld_st;
  logic              Dispatch_en_branch, Dispatch_illegal;

  int checks = 0;
  int errors = 0;

  dispatch_decoder #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .Inst_valid          (Inst_valid),
    .Inst                (Inst),
    .Inst_ready          (Inst_ready),
    .flush               (flush),
    .integer_full        (integer_full),
    .mult_full           (mult_full),
    .ld_st_full          (ld_st_full),
    .branch_full         (branch_full),
    .Dispatch_opcode     (Dispatch_opcode),
    .Dispatch_shfamt     (Dispatch_shfamt),
    .Dispatch_rs         (Dispatch_rs),
    .Dispatch_rt         (Dispatch_rt),
    .Dispatch_rd         (Dispatch_rd),
    .Dispatch_imm        (Dispatch_imm),
    .Dispatch_jmp_addr   (Dispatch_jmp_addr),
    .Dispatch_ld_st_op   (Dispatch_ld_st_op),
    .Dispatch_en_integer (Dispatch_en_integer),
    .Dispatch_en_mult    (Dispatch_en_mult),
    .Dispatch_en_ld_st   (Dispatch_en_ld_st),
    .Dispatch_en_branch  (Dispatch_en_branch),
    .Dispatch_illegal    (Dispatch_illegal)
  );

  always #5 clock = ~clock;

  // en vector packs {integer, mult, ld_st, branch, illegal}
  function automatic logic [4:0] ens();
    return {Dispatch_en_integer, Dispatch_en_mult, Dispatch_en_ld_st,
            Dispatch_en_branch, Dispatch_illegal};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    Inst_valid = 1'b1;
    Inst       = w;
    tick();
    Inst_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (Inst_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", Inst_ready);
    end
    checks++;
    if (ens() !== 5'b0 || Dispatch_opcode !== 4'd0 || Dispatch_imm !== '0 ||
        Dispatch_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs got en=%b op=%0d imm=%h rd=%0d want all 0",
               ens(), Dispatch_opcode, Dispatch_imm, Dispatch_rd);
    end
    reset = 1'b0;
  endtask

  task automatic test_add();
    push(W_ADD);
    checks++;
    if (ens() !== 5'b00000) begin
      errors++; $display("FAIL add_early got en=%b want 00000", ens());
    end
    tick();
    checks++;
    if (ens() !== 5'b10000 || Dispatch_opcode !== 4'd0 || Dispatch_rs !== 5'd1 ||
        Dispatch_rt !== 5'd2 || Dispatch_rd !== 5'd3) begin
      errors++;
      $display("FAIL add_issue got en=%b op=%0d rs=%0d rt=%0d rd=%0d want 10000 0 1 2 3",
               ens(), Dispatch_opcode, Dispatch_rs, Dispatch_rt, Dispatch_rd);
    end
    tick();
    checks++;
    if (ens() !== 5'b00000 || Dispatch_rd !== 5'd3) begin
      errors++; $display("FAIL add_pulse got en=%b rd=%0d want 00000 3", ens(), Dispatch_rd);
    end
  endtask

  task automatic test_imm();
    push(W_ADDI);
    tick();
    checks++;
    if (ens() !== 5'b10000 || Dispatch_imm !== 32'hFFFF_FFFC || Dispatch_rd !== 5'd5 ||
        Dispatch_opcode !== 4'd0) begin
      errors++;
      $display("FAIL addi got en=%b imm=%h rd=%0d op=%0d want 10000 fffffffc 5 0",
               ens(), Dispatch_imm, Dispatch_rd, Dispatch_opcode);
    end
    push(W_ORI);
    tick();
    checks++;
    if (ens() !== 5'b10000 || Dispatch_imm !== 32'h0000_FFFC || Dispatch_opcode !== 4'd4) begin
      errors++;
      $display("FAIL ori got en=%b imm=%h op=%0d want 10000 0000fffc 4",
               ens(), Dispatch_imm, Dispatch_opcode);
    end
  endtask

  task automatic test_ldst_stall();
    ld_st_full = 1'b1;
    push(W_LW);
    push(W_ADD);
    checks++;
    if (ens() !== 5'b00000) begin
      errors++; $display("FAIL lw_blocked1 got en=%b want 00000", ens());
    end
    tick();
    checks++;
    if (ens() !== 5'b00000 || Dispatch_opcode !== 4'd4 || Dispatch_imm !== 32'h0000_FFFC) begin
      errors++;
      $display("FAIL lw_blocked2 got en=%b op=%0d imm=%h want 00000 4 0000fffc",
               ens(), Dispatch_opcode, Dispatch_imm);
    end
    ld_st_full = 1'b0;
    tick();
    checks++;
    if (ens() !== 5'b00100 || Dispatch_ld_st_op !== 1'b0 || Dispatch_imm !== 32'd8 ||
        Dispatch_opcode !== 4'd0) begin
      errors++;
      $display("FAIL lw_issue got en=%b ldst=%b imm=%h op=%0d want 00100 0 00000008 0",
               ens(), Dispatch_ld_st_op, Dispatch_imm, Dispatch_opcode);
    end
    tick();
    checks++;
    if (ens() !== 5'b10000 || Dispatch_rd !== 5'd3) begin
      errors++; $display("FAIL add_behind_lw got en=%b rd=%0d want 10000 3", ens(), Dispatch_rd);
    end
    tick();
    checks++;
    if (ens() !== 5'b00000) begin
      errors++; $display("FAIL ldst_drain got en=%b want 00000", ens());
    end
  endtask

  task automatic test_mult_fill();
    mult_full  = 1'b1;
    Inst_valid = 1'b1;
    Inst       = W_MULT;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (Inst_ready !== (i < DEPTH - 1) || ens() !== 5'b00000) begin
        errors++;
        $display("FAIL mult_fill[%0d] got ready=%b en=%b want %b 00000",
                 i, Inst_ready, ens(), (i < DEPTH - 1));
      end
    end
    // An ADD offered on the release edge must be refused: the buffer is still full then
    Inst      = W_ADD;
    mult_full = 1'b0;
    tick();
    Inst_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (ens() !== 5'b01000 || Inst_ready !== 1'b1 || Dispatch_opcode !== 4'd0) begin
        errors++;
        $display("FAIL mult_drain[%0d] got en=%b ready=%b op=%0d want 01000 1 0",
                 i, ens(), Inst_ready, Dispatch_opcode);
      end
      tick();
    end
    checks++;
    if (ens() !== 5'b00000) begin
      errors++; $display("FAIL mult_full_accept got en=%b want 00000", ens());
    end
  endtask

  task automatic test_branch_shift();
    push(W_BEQ);
    push(W_J);
    checks++;
    if (ens() !== 5'b00010 || Dispatch_opcode !== 4'd2 || Dispatch_imm !== 32'd4 ||
        Dispatch_rd !== 5'd0) begin
      errors++;
      $display("FAIL beq got en=%b op=%0d imm=%h rd=%0d want 00010 2 00000004 0",
               ens(), Dispatch_opcode, Dispatch_imm, Dispatch_rd);
    end
    push(W_SRL);
    checks++;
    if (ens() !== 5'b00010 || Dispatch_opcode !== 4'd0 || Dispatch_jmp_addr !== 26'h10) begin
      errors++;
      $display("FAIL jump got en=%b op=%0d jmp=%h want 00010 0 0000010",
               ens(), Dispatch_opcode, Dispatch_jmp_addr);
    end
    tick();
    checks++;
    if (ens() !== 5'b10000 || Dispatch_opcode !== 4'd9 || Dispatch_shfamt !== 5'd4) begin
      errors++;
      $display("FAIL srl got en=%b op=%0d shamt=%0d want 10000 9 4",
               ens(), Dispatch_opcode, Dispatch_shfamt);
    end
    tick();
  endtask

  task automatic test_illegal();
    push(W_ILL);
    push(W_ADD);
    checks++;
    if (ens() !== 5'b00001) begin
      errors++; $display("FAIL illegal got en=%b want 00001", ens());
    end
    tick();
    checks++;
    if (ens() !== 5'b10000) begin
      errors++; $display("FAIL after_illegal got en=%b want 10000", ens());
    end
    tick();
  endtask

  task automatic test_flush();
    integer_full = 1'b1;
    push(W_ADD);
    push(W_SUB);
    push(W_ADD);
    flush        = 1'b1;
    Inst_valid   = 1'b1;
    Inst         = W_OR;
    integer_full = 1'b0;
    tick();
    flush      = 1'b0;
    Inst_valid = 1'b0;
    checks++;
    if (ens() !== 5'b00000 || Inst_ready !== 1'b1) begin
      errors++; $display("FAIL flush_edge got en=%b ready=%b want 00000 1", ens(), Inst_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ens() !== 5'b00000) begin
        errors++; $display("FAIL flush_empty[%0d] got en=%b want 00000", i, ens());
      end
    end
  endtask

  task automatic test_async_reset();
    push(W_ADD);
    push(W_SUB);
    checks++;
    if (ens() !== 5'b10000 || Dispatch_rd !== 5'd3) begin
      errors++; $display("FAIL pre_reset got en=%b rd=%0d want 10000 3", ens(), Dispatch_rd);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ens() !== 5'b00000 || Dispatch_rd !== 5'd0 || Dispatch_rs !== 5'd0 ||
        Dispatch_rt !== 5'd0) begin
      errors++;
      $display("FAIL async_reset got en=%b rs=%0d rt=%0d rd=%0d want 00000 0 0 0",
               ens(), Dispatch_rs, Dispatch_rt, Dispatch_rd);
    end
    #1 reset = 1'b0;
    tick();
    checks++;
    if (ens() !== 5'b00000 || Inst_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset got en=%b ready=%b want 00000 1", ens(), Inst_ready);
    end
  endtask

  initial begin
    reset        = 1'b1;
    Inst_valid   = 1'b0;
    Inst         = '0;
    flush        = 1'b0;
    integer_full = 1'b0;
    mult_full    = 1'b0;
    ld_st_full   = 1'b0;
    branch_full  = 1'b0;
    test_reset();
    test_add();
    test_imm();
    test_ldst_stall();
    test_mult_fill();
    test_branch_shift();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
